cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits between the I/D cache arbiter and main memory.
- Upstream, it accepts 256-bit cacheline read and write requests (cache_* interface) and returns a one-cycle response.
- Downstream, it converts each request into a 4-beat, 64-bit burst transaction on the memory port.
- Holds one request at a time; the upstream side is non-pipelined.

Parameters:
BEAT_W, 64, width of one memory burst beat
BEATS, 4, beats per cacheline; line width = BEAT_W*BEATS (256)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
cache_read  input  1  line read request, held until cache_resp
cache_write  input  1  line write request, held until cache_resp
cache_addr  input  32  line address; bits [4:0] ignored
cache_wdata  input  256  write line, valid while cache_write high
cache_resp  output  1  one-cycle completion pulse
cache_data  output  256  read line, valid from the cache_resp cycle until the next read completes
address_o  output  32  memory burst address, {cache_addr[31:5],5'b0}
read_o  output  1  memory burst read request
write_o  output  1  memory burst write request
burst_o  output  64  current write beat
burst_i  input  64  read beat from memory
resp_i  input  1  memory beat strobe; one beat transferred per cycle it is high

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, beat counter=0.
  - cache_resp, read_o, write_o = 0; address_o = 0; burst_o = 0; cache_data = 0.
  - Applies immediately, including mid-burst. Memory must be reset together with the adaptor.
- FSM states:
  - IDLE:
    - If cache_read: latch aligned address, clear counter, go to READ.
    - Else if cache_write: latch address and cache_wdata into the line buffer, clear counter, go to WRITE.
    - If both are high, read wins and the write is ignored; the arbiter never drives both.
    - Otherwise stay in IDLE.
  - READ:
    - read_o=1 and address_o=latched address, held stable for the whole burst.
    - Each cycle resp_i=1: buffer[cnt*64 +: 64] <= burst_i, cnt++.
    - Gaps (resp_i=0) are legal and stall the counter.
    - When the beat with cnt==BEATS-1 is captured, go to DONE; read_o drops in that next cycle.
  - WRITE:
    - write_o=1, address_o=latched address, burst_o=buffer[cnt*64 +: 64] (combinational from cnt).
    - Each cycle resp_i=1 consumes the current beat, cnt++.
    - After the last beat is consumed, go to DONE.
  - DONE:
    - cache_resp=1 for exactly one cycle, then go to IDLE.
    - For reads, cache_data is already updated and is held until the next read completes.
    - Writes do not modify cache_data.
- Beat order: beat 0 = line bits [63:0]; ascending.
- Latency: request sampled in IDLE at edge T; read_o/write_o high from T+1. If memory strobes beats at cycles A..A+3 (no gaps), cache_resp is high in cycle A+4. Minimum request-to-resp is 6 cycles.
- The upstream request is sampled only in IDLE. Changes to cache_addr/cache_wdata during a burst are ignored because values are latched.
- The requester deasserts the request in the cycle after cache_resp. The DONE→IDLE step guarantees a held-high request is not re-accepted in the cycle cache_resp is high. A request still high in IDLE after DONE starts a new transaction.
- resp_i outside READ/WRITE is ignored.
- Counter is 2 bits (log2 BEATS) and wraps to 0 after the last beat.

Test Plan:
- Reset mid-READ after 2 beats → read_o drops immediately (asynchronously, without waiting for clk); after release, cache_data=0 and state=IDLE; a new read completes normally.
- Read addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back:
  - address_o=0x0000_1220.
  - cache_data={0x44..,0x33..,0x22..,0x11..}.
  - cache_resp is a single pulse 1 cycle after the last beat.
- Write addr 0x8000_0040, wdata beats W0..W3:
  - write_o=1 throughout.
  - burst_o shows W0 until the first resp_i, then W1, W2, W3 in order.
  - One cache_resp pulse.
  - cache_data unchanged.
- Read with resp_i gaps (pattern 1,0,0,1,1,0,1) → 4 beats captured in the correct slots; cache_resp one cycle after the 7th strobe cycle.
- cache_read held high through cache_resp and one extra cycle → exactly two transactions start; no duplicate cache_resp within one transaction.
- cache_read and cache_write asserted together → read burst only (read_o=1, write_o=0).

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side bus bundle for cacheline_adaptor.
//   cache_*   : upstream line request / response from the I/D cache arbiter
//   address_o, read_o, write_o, burst_o : downstream burst request to memory
//   burst_i, resp_i                     : downstream read beat and beat strobe
// Modports:
//   slave  - the adaptor's view (takes cache requests, drives memory bursts)
//   master - the environment's view (arbiter plus memory)
interface cacheline_adaptor_if #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  localparam int LINE_W = BEAT_W * BEATS;

  logic              cache_read;
  logic              cache_write;
  logic [31:0]       cache_addr;
  logic [LINE_W-1:0] cache_wdata;
  logic              cache_resp;
  logic [LINE_W-1:0] cache_data;

  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;

  modport slave (
    input  cache_read, cache_write, cache_addr, cache_wdata,
    output cache_resp, cache_data,
    output address_o, read_o, write_o, burst_o,
    input  burst_i, resp_i
  );

  modport master (
    output cache_read, cache_write, cache_addr, cache_wdata,
    input  cache_resp, cache_data,
    input  address_o, read_o, write_o, burst_o,
    output burst_i, resp_i
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write request from the cache arbiter into a
// BEATS-beat, BEAT_W-bit burst on the memory port, then pulses cache_resp.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-low reset
//   bus - cacheline_adaptor_if.slave (cache_* upstream, burst port downstream)
// One request is held at a time; the upstream request is sampled only in IDLE.
module cacheline_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input logic               clk,
  input logic               rst,
  cacheline_adaptor_if.slave bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset bits of the request address.
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;   // write line being sent, or read line being filled
  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] cdata_q;  // last completed read line, stable across writes
  logic [31:0]       addr_q;
  logic              read_q;
  logic              write_q;
  logic              resp_q;

  // Line buffer with the incoming read beat merged into the current slot.
  always_comb begin
    line_d = line_q;
    line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = bus.burst_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      cdata_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Read has priority if both requests are ever seen together.
          if (bus.cache_read) begin
            addr_q  <= bus.cache_addr & ADDR_MASK;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= READ;
          end else if (bus.cache_write) begin
            addr_q  <= bus.cache_addr & ADDR_MASK;
            line_q  <= bus.cache_wdata;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_q <= line_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              // Publish the whole line at once so cache_data never shows a
              // partially filled line.
              cdata_q <= line_d;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // One dead cycle keeps a still-held request from being re-taken
          // while cache_resp is high.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cache_resp = resp_q;
  assign bus.cache_data = cdata_q;
  assign bus.address_o  = addr_q;
  assign bus.read_o     = read_q;
  assign bus.write_o    = write_q;
  assign bus.burst_o    = line_q[int'(cnt_q) * BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor with a transaction-level reference:
// each request is a whole line, memory returns/consumes 64-bit slices of it.
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus_if ();

  cacheline_adaptor #(.BEAT_W(64), .BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [255:0] exp_cdata = '0;
  logic [6:0]   pat = 7'b1011001;  // strobe sequence 1,0,0,1,1,0,1 (LSB first)

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [255:0] l, input int k);
    return l[k*64 +: 64];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue one request and play memory. Called and returns at #1 after posedge.
  // mode: 0 back-to-back strobes, 1 fixed gap pattern, 2 random gaps.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int mode);
    int k = 0;
    int p = 0;
    bit done = 0;
    logic strobe;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    bus_if.cache_read  = rd;
    bus_if.cache_write = wr;
    bus_if.cache_addr  = addr;
    bus_if.cache_wdata = wline;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        check("resp_after_last_beat", bus_if.cache_resp, 1'b1);
        if (rd) exp_cdata = rline;
        check("cache_data", bus_if.cache_data, exp_cdata);
        check("rw_low_in_resp", {bus_if.read_o, bus_if.write_o}, 2'b00);
        bus_if.cache_read  = 1'b0;
        bus_if.cache_write = 1'b0;
        bus_if.resp_i      = 1'($urandom_range(0, 1));  // must be ignored in DONE
        bus_if.burst_i     = {$urandom, $urandom};
        done = 1;
      end else begin
        check("no_early_resp", bus_if.cache_resp, 1'b0);
        check("read_o", bus_if.read_o, rd);
        check("write_o", bus_if.write_o, !rd);
        check("address_o", bus_if.address_o, exp_addr);
        if (!rd) check("burst_o", bus_if.burst_o, beat(wline, k));
        if (mode == 0)      strobe = 1'b1;
        else if (mode == 1) strobe = pat[p % 7];
        else                strobe = ($urandom_range(0, 2) != 0);
        p++;
        bus_if.resp_i  = strobe;
        bus_if.burst_i = (strobe && rd) ? beat(rline, k) : {$urandom, $urandom};
        if (strobe) k++;
      end
    end
    if (!done) begin
      check("timeout", 1'b0, 1'b1);
      bus_if.cache_read  = 1'b0;
      bus_if.cache_write = 1'b0;
    end
    @(posedge clk); #1;
    bus_if.resp_i = 1'b0;
    check("resp_single_pulse", bus_if.cache_resp, 1'b0);
    check("idle_after_done", {bus_if.read_o, bus_if.write_o}, 2'b00);
    check("cache_data_hold", bus_if.cache_data, exp_cdata);
  endtask

  initial begin
    logic [255:0] l;
    rst = 1'b0;
    bus_if.cache_read  = 1'b0;
    bus_if.cache_write = 1'b0;
    bus_if.cache_addr  = '0;
    bus_if.cache_wdata = '0;
    bus_if.burst_i     = '0;
    bus_if.resp_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", bus_if.cache_resp, 1'b0);
    check("rst_rw", {bus_if.read_o, bus_if.write_o}, 2'b00);
    check("rst_addr", bus_if.address_o, 32'h0);
    check("rst_burst_o", bus_if.burst_o, 64'h0);
    check("rst_cache_data", bus_if.cache_data, 256'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed read with known beats.
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h0000_1234, rand256(), l, 0);

    // Directed write; cache_data must stay at the previous read line.
    run_txn(1'b0, 1'b1, 32'h8000_0040, rand256(), rand256(), 0);

    // Read with strobe gaps.
    run_txn(1'b1, 1'b0, 32'h0000_5a7f, rand256(), rand256(), 1);

    // Asynchronous reset two beats into a read.
    bus_if.cache_read = 1'b1;
    bus_if.cache_addr = 32'h0000_3300;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus_if.resp_i  = 1'b1;
      bus_if.burst_i = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    bus_if.resp_i     = 1'b0;
    bus_if.cache_read = 1'b0;
    check("pre_rst_read_o", bus_if.read_o, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_read_o", bus_if.read_o, 1'b0);
    check("async_rst_addr", bus_if.address_o, 32'h0);
    check("async_rst_cache_data", bus_if.cache_data, 256'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cdata = '0;
    @(posedge clk); #1;
    check("post_rst_idle", {bus_if.read_o, bus_if.write_o, bus_if.cache_resp}, 3'b000);
    check("post_rst_burst_o", bus_if.burst_o, 64'h0);
    run_txn(1'b1, 1'b0, 32'hdead_beef, rand256(), rand256(), 0);

    // Read held high through cache_resp plus one cycle: two transactions.
    begin
      int nresp = 0;
      int nstart = 0;
      int hold = -1;
      int bi = 0;
      logic prev_rd = 1'b0;
      logic [255:0] acc = '0;
      bus_if.cache_read = 1'b1;
      bus_if.cache_addr = 32'h0000_0100;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (bus_if.read_o && !prev_rd) nstart++;
        prev_rd = bus_if.read_o;
        if (bus_if.cache_resp) begin
          nresp++;
          check("held_cache_data", bus_if.cache_data, acc);
          exp_cdata = acc;
          if (nresp == 1) hold = 2;
        end
        if (hold > 0) hold--;
        else if (hold == 0) begin
          bus_if.cache_read = 1'b0;
          hold = -1;
        end
        bus_if.resp_i = bus_if.read_o;
        bus_if.burst_i = {$urandom, $urandom};
        if (bus_if.read_o) begin
          acc[bi*64 +: 64] = bus_if.burst_i;
          bi = (bi + 1) % 4;
        end
      end
      bus_if.resp_i = 1'b0;
      check("held_two_starts", 32'(nstart), 32'd2);
      check("held_two_resps", 32'(nresp), 32'd2);
    end

    // Both requests together: only a read burst.
    run_txn(1'b1, 1'b1, 32'h0000_0a60, rand256(), rand256(), 0);

    // Random traffic with stray strobes while idle.
    for (int t = 0; t < 20; t++) begin
      logic rd = 1'($urandom_range(0, 1));
      logic wr = rd ? ($urandom_range(0, 4) == 0) : 1'b1;
      int idle = $urandom_range(0, 2);
      run_txn(rd, wr, $urandom, rand256(), rand256(), $urandom_range(0, 2));
      for (int i = 0; i < idle; i++) begin
        bus_if.resp_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("idle_stray_strobe", {bus_if.read_o, bus_if.write_o, bus_if.cache_resp}, 3'b000);
      end
      bus_if.resp_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
